// File: rtl/pipe_stage_elastic_pkg.sv
// Shared LC-3b pipeline types for the elastic stage.
// Occupancy encoding equals the number of entries held, so it drives the occupancy port directly.
package pipe_stage_elastic_pkg;

  typedef logic [15:0] lc3b_word;
  typedef logic [2:0]  lc3b_reg;

  typedef enum logic [1:0] {
    PIPE_EMPTY = 2'd0,
    PIPE_ONE   = 2'd1,
    PIPE_FULL  = 2'd2
  } pipe_occ_t;

  localparam int PIPE_DEPTH = 2;

endpackage

// File: rtl/pipe_stage_elastic_skid_slot.sv
// Load-enabled payload register used for both the main and the skid slot of the elastic stage.
module pipe_skid_slot
  import pipe_stage_elastic_pkg::*;
#(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/pipe_stage_elastic.sv
// Elastic pipeline register with a 2-entry skid buffer, registered up_ready and synchronous flush.
// Optional saturating stall/bubble counters are built when PIPE_STAGE_STATS_EN is defined.
//
//   state  | meaning
//   -------+-----------------------------------------------
//   EMPTY  | no entry held, dn_valid low
//   ONE    | main slot holds the head entry
//   FULL   | main holds head, skid holds next; up_ready low
module pipe_stage_elastic
  import pipe_stage_elastic_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int NUM_CH = 5,
  parameter int TAG_W  = 3,
  parameter int CW_W   = 32
`ifdef PIPE_STAGE_STATS_EN
  ,
  parameter int CNT_W  = 16
`endif
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     up_valid,
  output logic                     up_ready,
  input  logic [NUM_CH*DATA_W-1:0] up_data,
  input  logic [TAG_W-1:0]         up_dest,
  input  logic [CW_W-1:0]          up_cw,
  output logic                     dn_valid,
  input  logic                     dn_ready,
  output logic [NUM_CH*DATA_W-1:0] dn_data,
  output logic [TAG_W-1:0]         dn_dest,
  output logic [CW_W-1:0]          dn_cw,
  output logic [1:0]               occupancy
`ifdef PIPE_STAGE_STATS_EN
  ,
  output logic [CNT_W-1:0]         stall_cnt,
  output logic [CNT_W-1:0]         bubble_cnt
`endif
);

  localparam int PW = NUM_CH*DATA_W + TAG_W + CW_W;

  localparam logic [1:0] S_EMPTY = PIPE_EMPTY;
  localparam logic [1:0] S_ONE   = PIPE_ONE;
  localparam logic [1:0] S_FULL  = PIPE_FULL;

  logic [1:0]    state;
  logic [1:0]    state_nxt;
  logic          up_ready_q;
  logic          dn_valid_q;
  logic          up_fire;
  logic          dn_fire;
  logic          main_load;
  logic          skid_load;
  logic [PW-1:0] up_payload;
  logic [PW-1:0] main_d;
  logic [PW-1:0] main_q;
  logic [PW-1:0] skid_q;

  assign up_fire    = up_valid & up_ready_q;
  assign dn_fire    = dn_valid_q & dn_ready;
  assign up_payload = {up_data, up_dest, up_cw};

  always_comb begin
    state_nxt = state;
    main_load = 1'b0;
    skid_load = 1'b0;
    main_d    = up_payload;
    case (state)
      S_EMPTY: begin
        if (up_fire) begin
          state_nxt = S_ONE;
          main_load = 1'b1;
        end
      end
      S_ONE: begin
        if (up_fire && !dn_fire) begin
          state_nxt = S_FULL;
          skid_load = 1'b1;
        end else if (up_fire && dn_fire) begin
          main_load = 1'b1;
        end else if (dn_fire) begin
          state_nxt = S_EMPTY;
        end
      end
      S_FULL: begin
        if (dn_fire) begin
          state_nxt = S_ONE;
          main_load = 1'b1;
          main_d    = skid_q;
        end
      end
      default: state_nxt = S_EMPTY;
    endcase
    // Flush wins over everything; payload regs are left as-is since dn_valid masks them.
    if (flush) begin
      state_nxt = S_EMPTY;
      main_load = 1'b0;
      skid_load = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_EMPTY;
      up_ready_q <= 1'b1;
      dn_valid_q <= 1'b0;
    end else begin
      state      <= state_nxt;
      up_ready_q <= (state_nxt != S_FULL);
      dn_valid_q <= (state_nxt != S_EMPTY);
    end
  end

  pipe_skid_slot #(.W(PW)) u_main (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (main_load),
    .d     (main_d),
    .q     (main_q)
  );

  pipe_skid_slot #(.W(PW)) u_skid (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (skid_load),
    .d     (up_payload),
    .q     (skid_q)
  );

  assign up_ready  = up_ready_q;
  assign dn_valid  = dn_valid_q;
  assign occupancy = state;
  assign {dn_data, dn_dest, dn_cw} = main_q;

`ifdef PIPE_STAGE_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt  <= '0;
      bubble_cnt <= '0;
    end else begin
      if (dn_valid_q && !dn_ready && !(&stall_cnt)) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
      if (!dn_valid_q && !(&bubble_cnt)) begin
        bubble_cnt <= bubble_cnt + CNT_W'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Bench for pipe_stage_elastic: directed scenarios plus random traffic against a queue-based model.
module tb_pipe_stage_elastic;

  localparam int DATA_W = 16;
  localparam int NUM_CH = 5;
  localparam int TAG_W  = 3;
  localparam int CW_W   = 32;
  localparam int DW     = NUM_CH*DATA_W;
  localparam int PW     = DW + TAG_W + CW_W;

  typedef logic [PW-1:0] ent_t;

  logic          clk;
  logic          rst_n;
  logic          flush;
  logic          up_valid;
  logic          up_ready;
  logic [DW-1:0] up_data;
  logic [TAG_W-1:0] up_dest;
  logic [CW_W-1:0]  up_cw;
  logic          dn_valid;
  logic          dn_ready;
  logic [DW-1:0] dn_data;
  logic [TAG_W-1:0] dn_dest;
  logic [CW_W-1:0]  dn_cw;
  logic [1:0]    occupancy;

  int n_checks = 0;
  int n_fail   = 0;

  ent_t mq[$];
  int   m_stall;
  int   m_bubble;

`ifdef PIPE_STAGE_STATS_EN
  logic [15:0] stall_cnt;
  logic [15:0] bubble_cnt;
  logic        up_ready2;
  logic        dn_valid2;
  logic [DW-1:0] dn_data2;
  logic [TAG_W-1:0] dn_dest2;
  logic [CW_W-1:0]  dn_cw2;
  logic [1:0]  occupancy2;
  logic [1:0]  stall_cnt2;
  logic [1:0]  bubble_cnt2;
`endif

  pipe_stage_elastic #(
    .DATA_W(DATA_W), .NUM_CH(NUM_CH), .TAG_W(TAG_W), .CW_W(CW_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .up_valid  (up_valid),
    .up_ready  (up_ready),
    .up_data   (up_data),
    .up_dest   (up_dest),
    .up_cw     (up_cw),
    .dn_valid  (dn_valid),
    .dn_ready  (dn_ready),
    .dn_data   (dn_data),
    .dn_dest   (dn_dest),
    .dn_cw     (dn_cw),
    .occupancy (occupancy)
`ifdef PIPE_STAGE_STATS_EN
    ,
    .stall_cnt (stall_cnt),
    .bubble_cnt(bubble_cnt)
`endif
  );

`ifdef PIPE_STAGE_STATS_EN
  pipe_stage_elastic #(
    .DATA_W(DATA_W), .NUM_CH(NUM_CH), .TAG_W(TAG_W), .CW_W(CW_W), .CNT_W(2)
  ) dut_sat (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .up_valid  (up_valid),
    .up_ready  (up_ready2),
    .up_data   (up_data),
    .up_dest   (up_dest),
    .up_cw     (up_cw),
    .dn_valid  (dn_valid2),
    .dn_ready  (dn_ready),
    .dn_data   (dn_data2),
    .dn_dest   (dn_dest2),
    .dn_cw     (dn_cw2),
    .occupancy (occupancy2),
    .stall_cnt (stall_cnt2),
    .bubble_cnt(bubble_cnt2)
  );
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] rnd_data(input logic [15:0] ch0);
    logic [95:0] r;
    r = {$urandom(), $urandom(), $urandom()};
    return {r[DW-1:16], ch0};
  endfunction

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic check_all();
    ent_t h;
    chk("occupancy", 128'(occupancy), 128'(mq.size()));
    chk("dn_valid", 128'(dn_valid), 128'(mq.size() > 0));
    chk("up_ready", 128'(up_ready), 128'(mq.size() < 2));
    if (mq.size() > 0) begin
      h = mq[0];
      chk("dn_data", 128'(dn_data), 128'(h[PW-1 -: DW]));
      chk("dn_dest", 128'(dn_dest), 128'(h[CW_W +: TAG_W]));
      chk("dn_cw", 128'(dn_cw), 128'(h[CW_W-1:0]));
    end
`ifdef PIPE_STAGE_STATS_EN
    chk("stall_cnt", 128'(stall_cnt), 128'(sat(m_stall, 65535)));
    chk("bubble_cnt", 128'(bubble_cnt), 128'(sat(m_bubble, 65535)));
    chk("stall_cnt_sat", 128'(stall_cnt2), 128'(sat(m_stall, 3)));
    chk("bubble_cnt_sat", 128'(bubble_cnt2), 128'(sat(m_bubble, 3)));
`endif
  endtask

  // One clock: drive, let the edge happen, advance the model, compare.
  task automatic cyc(input logic v, input logic [DW-1:0] d, input logic rdy, input logic fl);
    logic [TAG_W-1:0] t;
    logic [CW_W-1:0]  c;
    bit f_up, f_dn;
    t = TAG_W'($urandom());
    c = $urandom();
    up_valid = v;
    up_data  = d;
    up_dest  = t;
    up_cw    = c;
    dn_ready = rdy;
    flush    = fl;
    f_up = v && (mq.size() < 2);
    f_dn = (mq.size() > 0) && rdy;
    if (mq.size() > 0 && !rdy) m_stall++;
    if (mq.size() == 0) m_bubble++;
    @(posedge clk);
    #1;
    if (fl) begin
      mq.delete();
    end else begin
      if (f_dn) void'(mq.pop_front());
      if (f_up) mq.push_back({d, t, c});
    end
    check_all();
  endtask

  initial begin
    rst_n = 1'b0;
    flush = 1'b0;
    up_valid = 1'b0;
    up_data = '0;
    up_dest = '0;
    up_cw = '0;
    dn_ready = 1'b0;
    m_stall = 0;
    m_bubble = 0;
    #12;
    chk("rst_dn_valid", 128'(dn_valid), 128'(0));
    chk("rst_up_ready", 128'(up_ready), 128'(1));
    chk("rst_occupancy", 128'(occupancy), 128'(0));
    chk("rst_dn_data", 128'(dn_data), 128'(0));
    chk("rst_dn_dest", 128'(dn_dest), 128'(0));
    chk("rst_dn_cw", 128'(dn_cw), 128'(0));
    rst_n = 1'b1;

    // Streaming with dn_ready held high
    for (int i = 0; i < 8; i++) begin
      cyc(1'b1, rnd_data(16'h3000 + 16'(i)), 1'b1, 1'b0);
      chk("stream_ch0", 128'(dn_data[15:0]), 128'(16'h3000 + 16'(i)));
      chk("stream_occ", 128'(occupancy), 128'(1));
    end
    cyc(1'b0, '0, 1'b1, 1'b0);
    chk("stream_drain", 128'(dn_valid), 128'(0));

    // Backpressure fills both slots; extra push while full is ignored
    cyc(1'b1, rnd_data(16'h1111), 1'b0, 1'b0);
    cyc(1'b1, rnd_data(16'h2222), 1'b0, 1'b0);
    chk("bp_occ", 128'(occupancy), 128'(2));
    chk("bp_up_ready", 128'(up_ready), 128'(0));
    cyc(1'b1, rnd_data(16'h4444), 1'b0, 1'b0);
    chk("bp_hold_ch0", 128'(dn_data[15:0]), 128'(16'h1111));
    cyc(1'b0, '0, 1'b1, 1'b0);
    chk("bp_second_ch0", 128'(dn_data[15:0]), 128'(16'h2222));
    chk("bp_up_ready_back", 128'(up_ready), 128'(1));
    cyc(1'b0, '0, 1'b1, 1'b0);
    chk("bp_empty", 128'(dn_valid), 128'(0));

    // Flush while full, with a concurrent push that must be dropped
    cyc(1'b1, rnd_data(16'h1010), 1'b0, 1'b0);
    cyc(1'b1, rnd_data(16'h2020), 1'b0, 1'b0);
    cyc(1'b1, rnd_data(16'h3333), 1'b0, 1'b1);
    chk("flush_dn_valid", 128'(dn_valid), 128'(0));
    chk("flush_occ", 128'(occupancy), 128'(0));
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, '0, 1'b1, 1'b0);
      chk("flush_no_c", 128'(dn_valid), 128'(0));
    end

    // Simultaneous push and pop in ONE
    cyc(1'b1, rnd_data(16'h5555), 1'b0, 1'b0);
    cyc(1'b1, rnd_data(16'h6666), 1'b1, 1'b0);
    chk("simul_occ", 128'(occupancy), 128'(1));
    chk("simul_ch0", 128'(dn_data[15:0]), 128'(16'h6666));
    cyc(1'b0, '0, 1'b1, 1'b0);
    chk("simul_drain", 128'(dn_valid), 128'(0));

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      cyc($urandom_range(0, 3) != 0, rnd_data(16'($urandom())),
          $urandom_range(0, 2) != 0, $urandom_range(0, 19) == 0);
    end

    // Asynchronous reset mid-stream
    cyc(1'b1, rnd_data(16'h7777), 1'b0, 1'b0);
    cyc(1'b1, rnd_data(16'h8888), 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    mq.delete();
    m_stall = 0;
    m_bubble = 0;
    chk("arst_dn_valid", 128'(dn_valid), 128'(0));
    chk("arst_up_ready", 128'(up_ready), 128'(1));
    chk("arst_occ", 128'(occupancy), 128'(0));
    up_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check_all();
    for (int i = 0; i < 40; i++) begin
      cyc($urandom_range(0, 1) != 0, rnd_data(16'($urandom())),
          $urandom_range(0, 1) != 0, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
